// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg
//   Shared definitions for the multicycle control slice:
//   - FSM state encoding (IF=000, ID=001, EX=010, MEM=011, WB=100)
//   - ALU operation codes consumed by the shared ALU
//   - opcode and funct7 constants for the supported RV32I subset
//   - funct3 -> ALU operation helper used by the decoder
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IF  = 3'b000,
      ST_ID  = 3'b001,
      ST_EX  = 3'b010,
      ST_MEM = 3'b011,
      ST_WB  = 3'b100
   } state_t;

   localparam logic [3:0] ALUOP_AND = 4'b0000;
   localparam logic [3:0] ALUOP_OR  = 4'b0001;
   localparam logic [3:0] ALUOP_ADD = 4'b0010;
   localparam logic [3:0] ALUOP_SLT = 4'b0100;
   localparam logic [3:0] ALUOP_XOR = 4'b0101;
   localparam logic [3:0] ALUOP_SUB = 4'b0110;
   localparam logic [3:0] ALUOP_LSR = 4'b1000;
   localparam logic [3:0] ALUOP_LSL = 4'b1001;
   localparam logic [3:0] ALUOP_ASR = 4'b1010;

   localparam logic [6:0] OPC_RTYPE = 7'b0110011;
   localparam logic [6:0] OPC_IALU  = 7'b0010011;
   localparam logic [6:0] OPC_LW    = 7'b0000011;
   localparam logic [6:0] OPC_SW    = 7'b0100011;
   localparam logic [6:0] OPC_BEQ   = 7'b1100011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // alt selects the instr[30] variant (SUB for 000, ASR for 101).
   function automatic logic [3:0] funct3_aluop(input logic [2:0] funct3, input logic alt);
      logic [3:0] op;
      op = ALUOP_ADD;
      case (funct3)
         3'b000:  op = alt ? ALUOP_SUB : ALUOP_ADD;
         3'b001:  op = ALUOP_LSL;
         3'b010:  op = ALUOP_SLT;
         3'b100:  op = ALUOP_XOR;
         3'b101:  op = alt ? ALUOP_ASR : ALUOP_LSR;
         3'b110:  op = ALUOP_OR;
         3'b111:  op = ALUOP_AND;
         default: op = ALUOP_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if
//   Bundle between the control FSM and the datapath.
//   master: controller side (reads instr/zero/dmem_ready, drives enables).
//   slave : datapath side.
//   Memory handshake: mem_read/mem_write is a request held high on every
//   MEM cycle; the access completes on the first cycle where the request
//   and dmem_ready are both high. dmem_ready is ignored outside MEM.
interface multicycle_ctrl_if #(
   parameter int INSTRET_W = 32
);
   logic [31:0]          instr;
   logic                 zero;
   logic                 dmem_ready;
   logic                 ir_write;
   logic [3:0]           alu_op;
   logic                 alu_src;
   logic                 mem_read;
   logic                 mem_write;
   logic                 mem_to_reg;
   logic                 reg_write;
   logic                 load_pc;
   logic                 pc_src;
   logic                 illegal;
   logic                 mem_fault;
   logic [INSTRET_W-1:0] instret;

   modport master (
      input  instr, zero, dmem_ready,
      output ir_write, alu_op, alu_src, mem_read, mem_write, mem_to_reg,
             reg_write, load_pc, pc_src, illegal, mem_fault, instret
   );

   modport slave (
      output instr, zero, dmem_ready,
      input  ir_write, alu_op, alu_src, mem_read, mem_write, mem_to_reg,
             reg_write, load_pc, pc_src, illegal, mem_fault, instret
   );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// alu_decoder
//   Combinational decode of opcode/funct3/funct7 into the ALU operation
//   and a legality flag for the supported RV32I subset.
//   Ports: opcode[6:0], funct3[2:0], funct7[6:0] (instr[31:25]) in;
//          alu_op[3:0], legal out.
module alu_decoder
   import multicycle_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [3:0] alu_op,
   output logic       legal
);

   always_comb begin
      alu_op = ALUOP_ADD;
      legal  = 1'b0;
      case (opcode)
         OPC_RTYPE: begin
            // Only the base funct7 or the alternate one on ADD/SUB and SRL/SRA.
            legal  = (funct3 != 3'b011) &&
                     ((funct7 == F7_BASE) ||
                      ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            alu_op = funct3_aluop(funct3, funct7[5]);
         end
         OPC_IALU: begin
            // Upper bits are immediate except for shifts, where they are shamt-funct7.
            case (funct3)
               3'b011:  legal = 1'b0;
               3'b001:  legal = (funct7 == F7_BASE);
               3'b101:  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
               default: legal = 1'b1;
            endcase
            // addi never becomes SUB; only srai uses instr[30].
            alu_op = funct3_aluop(funct3, (funct3 == 3'b101) && funct7[5]);
         end
         OPC_LW, OPC_SW: begin
            legal  = 1'b1;
            alu_op = ALUOP_ADD;
         end
         OPC_BEQ: begin
            legal  = 1'b1;
            alu_op = ALUOP_SUB;
         end
         default: begin
            legal  = 1'b0;
            alu_op = ALUOP_ADD;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multicycle IF/ID/EX/MEM/WB control FSM for the RV32I-subset core.
//   Ports:
//     clk    - system clock, rising edge
//     rst    - synchronous active-high reset; forces all enables to 0
//     bus    - multicycle_ctrl_if.master: instr/zero/dmem_ready in,
//              datapath enables, illegal/mem_fault pulses, instret out
//     state  - current FSM state, for observation
//   Parameters:
//     MEM_TIMEOUT - MEM cycles waited for dmem_ready (0 = no timeout, 0..255)
//     INSTRET_W   - retired-instruction counter width
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int INSTRET_W   = 32
) (
   input  logic                clk,
   input  logic                rst,
   multicycle_ctrl_if.master   bus,
   output state_t              state
);

   // Index (0-based) of the MEM cycle on which a missing ready faults.
   localparam int         TO_LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
   localparam logic [7:0] TO_LAST   = TO_LAST_I[7:0];
   localparam logic       TO_EN     = (MEM_TIMEOUT != 0);

   state_t               state_q;
   state_t               state_d;
   logic [7:0]           mem_cnt;
   logic [INSTRET_W-1:0] instret_q;
   logic                 retire;
   logic                 mem_timeout;

   logic [6:0] opcode;
   logic [3:0] dec_op;
   logic       dec_legal;
   logic       is_lw;
   logic       is_sw;
   logic       is_beq;

   assign opcode = bus.instr[6:0];
   assign is_lw  = (opcode == OPC_LW);
   assign is_sw  = (opcode == OPC_SW);
   assign is_beq = (opcode == OPC_BEQ);

   alu_decoder u_alu_decoder (
      .opcode (opcode),
      .funct3 (bus.instr[14:12]),
      .funct7 (bus.instr[31:25]),
      .alu_op (dec_op),
      .legal  (dec_legal)
   );

   // Ready on the last allowed cycle still completes the access.
   assign mem_timeout = TO_EN && (mem_cnt == TO_LAST) && !bus.dmem_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IF;
      end else begin
         state_q <= state_d;
      end
   end

   // MEM cycle counter: held at 0 outside MEM so every MEM entry starts fresh.
   always_ff @(posedge clk) begin
      if (rst || (state_q != ST_MEM)) begin
         mem_cnt <= '0;
      end else begin
         mem_cnt <= mem_cnt + 8'd1;
      end
   end

   // Retired-instruction counter, wraps naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         instret_q <= '0;
      end else if (retire) begin
         instret_q <= instret_q + 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IF: state_d = ST_ID;
         ST_ID: state_d = dec_legal ? ST_EX : ST_IF;
         ST_EX: begin
            if (is_beq) begin
               state_d = ST_IF;
            end else if (is_lw || is_sw) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            if (bus.dmem_ready) begin
               state_d = is_lw ? ST_WB : ST_IF;
            end else if (mem_timeout) begin
               state_d = ST_IF;
            end else begin
               state_d = ST_MEM;
            end
         end
         ST_WB:   state_d = ST_IF;
         default: state_d = ST_IF;
      endcase
   end

   // Output logic
   always_comb begin
      bus.ir_write   = 1'b0;
      bus.alu_op     = ALUOP_AND;
      bus.alu_src    = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.reg_write  = 1'b0;
      bus.load_pc    = 1'b0;
      bus.pc_src     = 1'b0;
      bus.illegal    = 1'b0;
      bus.mem_fault  = 1'b0;
      retire         = 1'b0;
      if (!rst) begin
         bus.alu_op = ALUOP_ADD;
         case (state_q)
            ST_IF: bus.ir_write = 1'b1;
            ST_ID: begin
               if (!dec_legal) begin
                  bus.illegal = 1'b1;
                  bus.load_pc = 1'b1;
               end
            end
            ST_EX: begin
               if (is_beq) begin
                  bus.alu_op  = ALUOP_SUB;
                  bus.load_pc = 1'b1;
                  bus.pc_src  = bus.zero;
                  retire      = 1'b1;
               end else if (is_lw || is_sw) begin
                  bus.alu_src = 1'b1;
               end else begin
                  bus.alu_op  = dec_op;
                  bus.alu_src = (opcode == OPC_IALU);
               end
            end
            ST_MEM: begin
               bus.mem_read  = is_lw;
               bus.mem_write = is_sw;
               if (bus.dmem_ready) begin
                  if (is_sw) begin
                     bus.load_pc = 1'b1;
                     retire      = 1'b1;
                  end
               end else if (mem_timeout) begin
                  bus.mem_fault = 1'b1;
                  bus.load_pc   = 1'b1;
               end
            end
            ST_WB: begin
               bus.reg_write  = 1'b1;
               bus.mem_to_reg = is_lw;
               bus.load_pc    = 1'b1;
               retire         = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.instret = instret_q;
   assign state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl. Each instruction pushes its expected
//   per-cycle {state, control word} sequence into exp_q; every cycle pops one
//   entry and compares it, plus the retired-instruction count.
module tb_multicycle_ctrl;

   localparam int W  = 17;
   localparam int TO = 16;

   localparam logic [3:0] A_AND = 4'b0000;
   localparam logic [3:0] A_OR  = 4'b0001;
   localparam logic [3:0] A_ADD = 4'b0010;
   localparam logic [3:0] A_SLT = 4'b0100;
   localparam logic [3:0] A_XOR = 4'b0101;
   localparam logic [3:0] A_SUB = 4'b0110;
   localparam logic [3:0] A_ASR = 4'b1010;

   localparam logic [2:0] S_IF  = 3'b000;
   localparam logic [2:0] S_ID  = 3'b001;
   localparam logic [2:0] S_EX  = 3'b010;
   localparam logic [2:0] S_MEM = 3'b011;
   localparam logic [2:0] S_WB  = 3'b100;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   multicycle_ctrl_if #(.INSTRET_W(32)) bus ();
   multicycle_ctrl_pkg::state_t state;

   multicycle_ctrl #(.MEM_TIMEOUT(TO), .INSTRET_W(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .state (state)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   logic [31:0]  exp_instret;
   int           checks = 0;
   int           errors = 0;

   // {state, ir_write, alu_op, alu_src, mem_read, mem_write, mem_to_reg,
   //  reg_write, load_pc, pc_src, illegal, mem_fault}
   function automatic logic [W-1:0] cw(input logic [2:0] st, input logic ir,
                                       input logic [3:0] op, input logic src,
                                       input logic mr, input logic mw, input logic m2r,
                                       input logic rw, input logic lp, input logic ps,
                                       input logic ill, input logic mf);
      return {st, ir, op, src, mr, mw, m2r, rw, lp, ps, ill, mf};
   endfunction

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   // ---------------- driver ----------------
   task automatic step(input logic rdy, input logic z, input logic r, input string tag);
      logic [W-1:0] o;
      logic [W-1:0] e;
      rst            = r;
      bus.dmem_ready = rdy;
      bus.zero       = z;
      @(negedge clk);
      o = {state, bus.ir_write, bus.alu_op, bus.alu_src, bus.mem_read, bus.mem_write,
           bus.mem_to_reg, bus.reg_write, bus.load_pc, bus.pc_src, bus.illegal, bus.mem_fault};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s queue_empty obs=%h", tag, o);
      end else begin
         e = exp_q.pop_front();
         assert (o === e) else begin
            errors++;
            $error("FAIL %s ctrl obs=%h exp=%h", tag, o, e);
         end
      end
      checks++;
      assert (bus.instret === exp_instret) else begin
         errors++;
         $error("FAIL %s instret obs=%0d exp=%0d", tag, bus.instret, exp_instret);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_if_id();
      exp_q.push_back(cw(S_IF, 1, A_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(cw(S_ID, 0, A_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic run_alu(input logic [31:0] ins, input logic [3:0] op,
                          input logic src, input string tag);
      bus.instr = ins;
      push_if_id();
      exp_q.push_back(cw(S_EX, 0, op,    src, 0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(cw(S_WB, 0, A_ADD, 0,   0, 0, 0, 1, 1, 0, 0, 0));
      repeat (4) step(rnd(), rnd(), 1'b0, tag);
      exp_instret++;
   endtask

   task automatic run_illegal(input logic [31:0] ins, input string tag);
      bus.instr = ins;
      exp_q.push_back(cw(S_IF, 1, A_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(cw(S_ID, 0, A_ADD, 0, 0, 0, 0, 0, 1, 0, 1, 0));
      repeat (2) step(rnd(), rnd(), 1'b0, tag);
   endtask

   task automatic run_beq(input logic [31:0] ins, input logic z, input string tag);
      bus.instr = ins;
      push_if_id();
      exp_q.push_back(cw(S_EX, 0, A_SUB, 0, 0, 0, 0, 0, 1, z, 0, 0));
      repeat (2) step(rnd(), rnd(), 1'b0, tag);
      step(rnd(), z, 1'b0, tag);
      exp_instret++;
   endtask

   task automatic run_lw(input logic [31:0] ins, input int waits, input string tag);
      bus.instr = ins;
      push_if_id();
      exp_q.push_back(cw(S_EX, 0, A_ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k <= waits; k++)
         exp_q.push_back(cw(S_MEM, 0, A_ADD, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(cw(S_WB, 0, A_ADD, 0, 0, 0, 1, 1, 1, 0, 0, 0));
      repeat (3) step(rnd(), rnd(), 1'b0, tag);
      repeat (waits) step(1'b0, rnd(), 1'b0, tag);
      step(1'b1, rnd(), 1'b0, tag);
      step(rnd(), rnd(), 1'b0, tag);
      exp_instret++;
   endtask

   // ready_at: MEM cycle (1-based) where dmem_ready rises; 0 = never.
   task automatic run_sw(input logic [31:0] ins, input int ready_at, input string tag);
      bool_done: begin end
      bus.instr = ins;
      push_if_id();
      exp_q.push_back(cw(S_EX, 0, A_ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (3) step(rnd(), rnd(), 1'b0, tag);
      for (int k = 1; k <= TO; k++) begin
         if (k == ready_at) begin
            exp_q.push_back(cw(S_MEM, 0, A_ADD, 0, 0, 1, 0, 0, 1, 0, 0, 0));
            step(1'b1, rnd(), 1'b0, tag);
            exp_instret++;
            break;
         end else if (k == TO) begin
            exp_q.push_back(cw(S_MEM, 0, A_ADD, 0, 0, 1, 0, 0, 1, 0, 0, 1));
            step(1'b0, rnd(), 1'b0, tag);
         end else begin
            exp_q.push_back(cw(S_MEM, 0, A_ADD, 0, 0, 1, 0, 0, 0, 0, 0, 0));
            step(1'b0, rnd(), 1'b0, tag);
         end
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst            = 1'b1;
      bus.instr      = 32'h002081B3;
      bus.dmem_ready = 1'b1;
      bus.zero       = 1'b1;
      exp_instret    = '0;
      repeat (3) @(posedge clk);
      #1;

      // Reset: everything 0, including alu_op.
      exp_q.push_back(cw(S_IF, 0, A_AND, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step(1'b1, 1'b1, 1'b1, "reset");

      run_alu(32'h002081B3, A_ADD, 1'b0, "add");
      run_alu(32'h40208133, A_SUB, 1'b0, "sub");
      run_alu(32'h4032D293, A_ASR, 1'b1, "srai");
      run_alu(32'h0020E1B3, A_OR,  1'b0, "or");
      run_alu(32'h0020C1B3, A_XOR, 1'b0, "xor");
      run_alu(32'h0020A1B3, A_SLT, 1'b0, "slt");
      run_alu(32'h0FF0F093, A_AND, 1'b1, "andi");
      run_alu(32'h40008093, A_ADD, 1'b1, "addi_bit30");

      run_lw(32'h0000A183, 3, "lw_wait3");
      run_lw(32'h0000A183, 0, "lw_fast");

      run_beq(32'h00000463, 1'b1, "beq_taken");
      run_beq(32'h00000463, 1'b0, "beq_not_taken");

      run_illegal(32'hFFFFFFFF, "ill_opcode");
      run_illegal(32'h0020B1B3, "ill_funct3");
      run_illegal(32'h022081B3, "ill_funct7");
      run_illegal(32'h4020E1B3, "ill_alt_or");
      run_illegal(32'h40109093, "ill_slli_alt");

      run_sw(32'h0020A023, 1,  "sw_fast");
      run_sw(32'h0020A023, 0,  "sw_timeout");
      run_sw(32'h0020A023, TO, "sw_ready_last");

      // Reset on the 5th MEM cycle of a stalled store.
      bus.instr = 32'h0020A023;
      push_if_id();
      exp_q.push_back(cw(S_EX, 0, A_ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (4) exp_q.push_back(cw(S_MEM, 0, A_ADD, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(cw(S_MEM, 0, A_AND, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (3) step(rnd(), rnd(), 1'b0, "sw_rst");
      repeat (4) step(1'b0, rnd(), 1'b0, "sw_rst_mem");
      step(1'b0, rnd(), 1'b1, "sw_rst_asserted");
      exp_instret = '0;

      run_alu(32'h002081B3, A_ADD, 1'b0, "add_after_rst");

      checks++;
      assert (bus.instret === exp_instret) else begin
         errors++;
         $error("FAIL final_instret obs=%0d exp=%0d", bus.instret, exp_instret);
      end

      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL leftover_expected obs=%0d exp=0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
